// File: rtl/case_7_mul_pkg.sv
// Shared types and constant helpers for the pipelined, flow-controlled multiplier.
package case_7_mul_pkg;

  localparam int PROD_MAX_W = 32;

  typedef struct packed {
    logic [PROD_MAX_W-1:0] product;
    logic                  is_signed;
  } stage_payload_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Low w bits of the result hold the largest value representable in w bits.
  function automatic logic [PROD_MAX_W-1:0] sat_max(input int w, input logic sgn);
    logic [PROD_MAX_W-1:0] one;
    one = 1;
    return sgn ? ((one << (w - 1)) - one) : ((one << w) - one);
  endfunction

  function automatic logic [PROD_MAX_W-1:0] sat_min(input int w, input logic sgn);
    logic [PROD_MAX_W-1:0] one;
    one = 1;
    return sgn ? (one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/case_7_mul_stage_reg.sv
// One bubble-collapsing pipeline stage: a valid bit plus payload, loading whenever
// it is empty or its current beat moves downstream in the same cycle.
module case_7_mul_stage_reg
  import case_7_mul_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           ce_i,
  input  logic           up_valid_i,
  input  stage_payload_t up_data_i,
  input  logic           down_ready_i,
  output logic           up_ready_o,
  output logic           valid_o,
  output stage_payload_t data_o
);

  logic           valid_q, valid_d;
  stage_payload_t data_q, data_d;
  logic           adv, load;

  always_comb begin
    adv        = ce_i & valid_q & down_ready_i;
    up_ready_o = ce_i & (~valid_q | adv);
    load       = up_valid_i & up_ready_o;
    valid_d    = valid_q;
    data_d     = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = up_data_i;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/case_7_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control, clock enable
// and wrap or saturate output formatting with an overflow flag.
module case_7_mul_pipe_hs
  import case_7_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 10,
  parameter int SAT_EN     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_signed,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int DW = dout_WIDTH;
  localparam logic [PROD_MAX_W-1:0] SMAX = sat_max(DW, 1'b1);
  localparam logic [PROD_MAX_W-1:0] SMIN = sat_min(DW, 1'b1);
  localparam logic [PROD_MAX_W-1:0] UMAX = sat_max(DW, 1'b0);
  localparam int unused_id = ID;

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stages
    $error("case_7_mul_pipe_hs: NUM_STAGE must be in 1..8");
  end
  if (DW > PW || PW > PROD_MAX_W) begin : g_bad_widths
    $error("case_7_mul_pipe_hs: illegal operand/result widths");
  end

  // Extending both operands to the full product width makes the low PW bits of a
  // single unsigned multiply correct for either mode.
  logic [PW-1:0]  a_ext, b_ext, prod;
  stage_payload_t s0_payload;

  always_comb begin
    if (is_signed) begin
      a_ext = PW'($signed(din0));
      b_ext = PW'($signed(din1));
    end else begin
      a_ext = PW'(din0);
      b_ext = PW'(din1);
    end
    prod                 = a_ext * b_ext;
    s0_payload.product   = PROD_MAX_W'(prod);
    s0_payload.is_signed = is_signed;
  end

  logic [NUM_STAGE-1:0] vchain, rchain;
  stage_payload_t       pchain [NUM_STAGE];

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic           up_v, dn_r;
    stage_payload_t up_d;

    if (k == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = s0_payload;
    end else begin : g_chain
      assign up_v = vchain[k-1];
      assign up_d = pchain[k-1];
    end

    if (k == NUM_STAGE - 1) begin : g_last
      assign dn_r = out_ready;
    end else begin : g_inner
      assign dn_r = rchain[k+1];
    end

    case_7_mul_stage_reg u_stage (
      .clk_i       (ap_clk),
      .rst_ni      (ap_rst_n),
      .ce_i        (ce),
      .up_valid_i  (up_v),
      .up_data_i   (up_d),
      .down_ready_i(dn_r),
      .up_ready_o  (rchain[k]),
      .valid_o     (vchain[k]),
      .data_o      (pchain[k])
    );
  end

  assign in_ready  = rchain[0];
  assign out_valid = vchain[NUM_STAGE-1];

  // Overflow means the product no longer round-trips through a DW-bit value of the
  // beat's mode; saturation picks the bound by the sign of the full product.
  logic [PW-1:0] p, sx, zx;
  logic          sgn, ovf_c;
  logic          unused_hi;

  always_comb begin
    p         = pchain[NUM_STAGE-1].product[PW-1:0];
    sgn       = pchain[NUM_STAGE-1].is_signed;
    unused_hi = ^pchain[NUM_STAGE-1].product;
    sx        = PW'($signed(p[DW-1:0]));
    zx        = PW'(p[DW-1:0]);
    ovf_c     = sgn ? (p != sx) : (p != zx);
    dout      = p[DW-1:0];
    if (SAT_EN != 0 && ovf_c) begin
      if (sgn && p[PW-1]) begin
        dout = SMIN[DW-1:0];
      end else if (sgn) begin
        dout = SMAX[DW-1:0];
      end else begin
        dout = UMAX[DW-1:0];
      end
    end
    ovf = ovf_c;
  end

endmodule

// File: tb/tb_case_7_mul_pipe_hs.sv
// Scoreboard bench: wrap and saturating instances share stimulus; monitors pop
// hand-computed expectations whenever a result beat is accepted.
module tb_case_7_mul_pipe_hs;

  typedef struct packed {
    logic [9:0] dout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN, ce, inValid, isSigned, outReady;
  logic [9:0] din0;
  logic [4:0] din1;
  logic       inReady0, inReady1, outValid0, outValid1, ovf0, ovf1;
  logic [9:0] dout0, dout1;

  exp_t q0[$];
  exp_t q1[$];
  int   nVec  = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  case_7_mul_pipe_hs #(.SAT_EN(0)) dutWrap (
    .ap_clk(clk), .ap_rst_n(rstN), .ce(ce), .in_valid(inValid), .in_ready(inReady0),
    .is_signed(isSigned), .din0(din0), .din1(din1), .out_valid(outValid0),
    .out_ready(outReady), .dout(dout0), .ovf(ovf0)
  );

  case_7_mul_pipe_hs #(.SAT_EN(1)) dutSat (
    .ap_clk(clk), .ap_rst_n(rstN), .ce(ce), .in_valid(inValid), .in_ready(inReady1),
    .is_signed(isSigned), .din0(din0), .din1(din1), .out_valid(outValid1),
    .out_ready(outReady), .dout(dout1), .ovf(ovf1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the wrap instance, including the output hold rule under stall.
  logic       held0 = 1'b0;
  logic [9:0] hD0;
  logic       hO0;
  always @(negedge clk) begin
    if (!rstN) begin
      held0 = 1'b0;
    end else begin
      if (held0) begin
        checkOutput("hold_valid0", outValid0, 1);
        checkOutput("hold_dout0", dout0, hD0);
        checkOutput("hold_ovf0", ovf0, hO0);
      end
      if (outValid0 && ce && outReady) begin
        held0 = 1'b0;
        if (q0.size() == 0) begin
          nVec++; nFail++;
          $display("[TB] FAIL spurious_out0: got beat %0h, expected none", dout0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          checkOutput("dout0", dout0, e.dout);
          checkOutput("ovf0", ovf0, e.ovf);
        end
      end else if (outValid0) begin
        held0 = 1'b1; hD0 = dout0; hO0 = ovf0;
      end else begin
        held0 = 1'b0;
      end
    end
  end

  // Monitor for the saturating instance.
  logic       held1 = 1'b0;
  logic [9:0] hD1;
  logic       hO1;
  always @(negedge clk) begin
    if (!rstN) begin
      held1 = 1'b0;
    end else begin
      if (held1) begin
        checkOutput("hold_valid1", outValid1, 1);
        checkOutput("hold_dout1", dout1, hD1);
        checkOutput("hold_ovf1", ovf1, hO1);
      end
      if (outValid1 && ce && outReady) begin
        held1 = 1'b0;
        if (q1.size() == 0) begin
          nVec++; nFail++;
          $display("[TB] FAIL spurious_out1: got beat %0h, expected none", dout1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          checkOutput("dout1", dout1, e.dout);
          checkOutput("ovf1", ovf1, e.ovf);
        end
      end else if (outValid1) begin
        held1 = 1'b1; hD1 = dout1; hO1 = ovf1;
      end else begin
        held1 = 1'b0;
      end
    end
  end

  task automatic pushExp(input logic [9:0] e0, input logic o0, input logic [9:0] e1, input logic o1);
    exp_t e;
    e.dout = e0; e.ovf = o0; q0.push_back(e);
    e.dout = e1; e.ovf = o1; q1.push_back(e);
  endtask

  // Offers one beat until accepted; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [9:0] a, input logic [4:0] b, input logic s,
                               input logic [9:0] e0, input logic o0,
                               input logic [9:0] e1, input logic o1);
    bit accepted;
    accepted = 0;
    inValid  = 1'b1; din0 = a; din1 = b; isSigned = s;
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (inReady0) begin
        pushExp(e0, o0, e1, o1);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    if (!accepted) begin
      nVec++; nFail++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, expected 1");
    end
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 60 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      nVec++; nFail++;
      $display("[TB] FAIL drain: got %0d/%0d beats outstanding, expected 0", q0.size(), q1.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         sent;
    int         lat;
    logic       snapV;
    logic [9:0] snapD0, snapD1;

    rstN = 1'b0; ce = 1'b1; inValid = 1'b0; isSigned = 1'b0; outReady = 1'b1;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid0", outValid0, 0);
    checkOutput("rst_valid1", outValid1, 0);
    checkOutput("rst_dout0", dout0, 0);
    checkOutput("rst_ovf0", ovf0, 0);
    rstN = 1'b1;
    #1;
    checkOutput("rst_in_ready0", inReady0, 1);
    checkOutput("rst_in_ready1", inReady1, 1);
    @(posedge clk); #1;

    // Directed vectors: {din0, din1, signed, wrap dout, wrap ovf, sat dout, sat ovf}
    applyStimulus(10'd100, 5'h1D, 1, 10'h2D4, 0, 10'h2D4, 0);
    applyStimulus(10'h200, 5'h10, 1, 10'h000, 1, 10'h1FF, 1);
    applyStimulus(10'h200, 5'h0F, 1, 10'h200, 1, 10'h200, 1);
    applyStimulus(10'h3FF, 5'h1F, 0, 10'h3E1, 1, 10'h3FF, 1);
    applyStimulus(10'h1FF, 5'h01, 1, 10'h1FF, 0, 10'h1FF, 0);
    applyStimulus(10'h200, 5'h01, 1, 10'h200, 0, 10'h200, 0);
    applyStimulus(10'h200, 5'h1F, 1, 10'h200, 1, 10'h1FF, 1);
    applyStimulus(10'h3FF, 5'h1F, 1, 10'h001, 0, 10'h001, 0);
    applyStimulus(10'h040, 5'h08, 1, 10'h200, 1, 10'h1FF, 1);
    applyStimulus(10'h3DF, 5'h10, 1, 10'h210, 1, 10'h1FF, 1);
    applyStimulus(10'h040, 5'h10, 0, 10'h000, 1, 10'h3FF, 1);
    applyStimulus(10'h000, 5'h1F, 0, 10'h000, 0, 10'h000, 0);
    applyStimulus(10'h3FF, 5'h01, 0, 10'h3FF, 0, 10'h3FF, 0);
    waitDrain();

    // Back-pressure: out_ready low in cycles 4..8 of a 10-beat stream.
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      outReady = !(c >= 4 && c <= 8);
      inValid  = (sent < 10);
      din0     = 10'(sent); din1 = 5'd1; isSigned = 1'b1;
      @(negedge clk);
      if (c >= 4 && c <= 8) checkOutput("bp_in_ready", inReady0, 0);
      if (inValid && inReady0) begin
        pushExp(10'(sent), 0, 10'(sent), 0);
        sent++;
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0; outReady = 1'b1;
    waitDrain();

    // Clock enable low for 4 cycles mid-stream.
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      ce      = !(c >= 3 && c <= 6);
      inValid = (sent < 8);
      din0    = 10'(sent + 20); din1 = 5'h1F; isSigned = 1'b1;
      @(negedge clk);
      if (c == 3) begin
        snapV = outValid0; snapD0 = dout0; snapD1 = dout1;
        checkOutput("ce_valid_at_freeze", outValid0, 1);
      end
      if (c >= 3 && c <= 6) begin
        checkOutput("ce_in_ready0", inReady0, 0);
        checkOutput("ce_in_ready1", inReady1, 0);
      end
      if (c > 3 && c <= 6) begin
        checkOutput("ce_valid_hold", outValid0, snapV);
        checkOutput("ce_dout0_hold", dout0, snapD0);
        checkOutput("ce_dout1_hold", dout1, snapD1);
      end
      if (inValid && inReady0) begin
        pushExp(10'(-(sent + 20)), 0, 10'(-(sent + 20)), 0);
        sent++;
      end
      @(posedge clk); #1;
    end
    ce = 1'b1; inValid = 1'b0;
    waitDrain();

    // Reset while beats are in flight and one is stalled at the output.
    outReady = 1'b0;
    applyStimulus(10'd7, 5'd2, 0, 10'd14, 0, 10'd14, 0);
    applyStimulus(10'd8, 5'd2, 0, 10'd16, 0, 10'd16, 0);
    applyStimulus(10'd9, 5'd2, 0, 10'd18, 0, 10'd18, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre_rst_valid", outValid0, 1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_valid0", outValid0, 0);
    checkOutput("mid_rst_valid1", outValid1, 0);
    checkOutput("mid_rst_dout0", dout0, 0);
    checkOutput("mid_rst_dout1", dout1, 0);
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1; outReady = 1'b1;
    applyStimulus(10'h3FF, 5'h01, 0, 10'h3FF, 0, 10'h3FF, 0);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (outValid0) lat = k;
    end
    checkOutput("rst_latency", 32'(lat), 3);
    @(posedge clk); #1;
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/case_7_mul_pipe_hs.md
Name: case_7_mul_pipe_hs

Overview:
Parametrised, pipelined, flow-controlled successor to the single-cycle HLS multiplier cores. It multiplies two operands in signed or unsigned mode, selected per transaction, through a NUM_STAGE-deep register pipeline. The output is either truncated (wrap) or saturated to dout_WIDTH, with an overflow flag. It sits between HLS datapath stages that use valid/ready streaming, and supports back-pressure and a global clock enable.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline depth in register stages; legal range 1..8.
- din0_WIDTH, 10, operand A width.
- din1_WIDTH, 5, operand B width.
- dout_WIDTH, 10, result width; must be at most din0_WIDTH+din1_WIDTH (elaboration error otherwise).
- SAT_EN, 0, 0 = wrap (keep the low dout_WIDTH bits); 1 = clamp to the dout_WIDTH range of the transaction's mode.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, all state holds.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- is_signed  in  1  mode for this beat: 1 = both operands two's complement, 0 = both unsigned.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  dout_WIDTH  result.
- ovf  out  1  the full product did not fit in dout_WIDTH for the beat's mode; qualified by out_valid.

Behaviour:
- Reset (async assert, release synchronised to ap_clk): all stage valid bits 0; out_valid=0; dout=0; ovf=0; data registers 0. in_ready=1 as soon as reset deasserts.
- Stage model: stages 0..NUM_STAGE-1, each holding a valid bit v[k], the product, and the mode.
  - adv[last] = v[last] & out_ready.
  - adv[k] = v[k] & (!v[k+1] | adv[k+1]).
  - Stage 0 loads when in_valid & in_ready.
  - This is a bubble-collapsing pipeline.
- in_ready = ce & (!v[0] | adv[0]). It is combinational from out_ready through the chain; this path is accepted.
- ce=0: no stage loads or advances; in_ready=0; out_valid and dout hold their values. Every handshake is qualified by ce.
- Latency: a beat accepted in cycle t gives out_valid=1 in cycle t+NUM_STAGE when there are no stalls. Throughput is 1 beat per cycle while out_ready=1.
- Arithmetic:
  - The full product P has width din0_WIDTH+din1_WIDTH.
  - Signed mode: P = signed(din0)*signed(din1). Unsigned mode: zero-extended operands.
  - The product may be formed in stage 0, or split and retimed across stages. Only the result at the output is specified.
- Output formatting at the final stage:
  - Wrap: dout = P[dout_WIDTH-1:0].
  - Signed overflow: P is outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - Unsigned overflow: P >= 2^dout_WIDTH.
  - SAT_EN=1: on overflow, dout = max value on positive overflow, min value on negative overflow. Unsigned min is 0 and is unreachable.
  - ovf is reported in both SAT_EN modes.
- Hold rule: while out_valid=1 & out_ready=0, dout, ovf and out_valid stay stable until the beat is accepted.
- Same-cycle accept and issue: when the pipeline is full and out_ready=1, a new input is accepted in the same cycle. No beat is lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded. No out_valid pulse occurs after reset deasserts until a new beat has travelled the pipeline.
- NUM_STAGE=1: the product is registered once and output directly. The handshake rules are unchanged.

Decomposition:
- Shared package case_7_mul_pkg:
  - sat_max/sat_min constant functions, taking width and mode.
  - A function giving product width from the operand widths.
  - A stage payload struct: product, is_signed.
- One sub-module, case_7_mul_stage_reg: a single valid/payload stage with load/advance logic, instantiated NUM_STAGE times in a generate loop.
- The formatter (wrap/saturate/ovf) stays inline in the top.

Test Plan:
All scenarios use default parameters unless stated. The width of dout is 10 bits.
- Signed, SAT_EN=0: din0=100, din1=-3 -> after 3 cycles dout=10'h2D4 (-300), ovf=0.
- Signed, din0=-512, din1=-16 (P=8192):
  - SAT_EN=0 -> dout=10'h000, ovf=1.
  - SAT_EN=1 -> dout=10'h1FF, ovf=1.
- Signed, SAT_EN=1: din0=-512, din1=15 -> dout=10'h200, ovf=1.
- Unsigned, din0=10'h3FF, din1=5'h1F (P=31713):
  - SAT_EN=0 -> dout=10'h3E1, ovf=1.
  - SAT_EN=1 -> dout=10'h3FF.
- Back-pressure: stream in 10 beats (din0=i, din1=1, signed) with out_ready low in cycles 4..8:
  - in_ready drops once 3 beats are held.
  - Outputs are 0..9 in order, no gaps or duplicates.
  - dout is stable while stalled.
- ce low for 4 cycles mid-stream -> all state frozen and in_ready=0. On reset pulse mid-stream -> out_valid=0 and dout=0 immediately, and the first out_valid occurs exactly 3 cycles after the first post-reset accept.
